// File: rtl/vscale_tohost_pkg.sv
// Shared types and constants for the vscale tohost end-of-test monitor.
package vscale_tohost_pkg;

    // Global verdict state; the three non-RUN states are terminal until reset.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } tohost_state_e;

    // tohost value that signals a passing hart.
    localparam int TOHOST_PASS    = 1;
    // Byte offset of the console word relative to a hart's tohost word.
    localparam int CONSOLE_OFFSET = 4;

    // Width needed to index a hart; never narrower than one bit.
    function automatic int hart_idx_width(input int num_harts);
        return (num_harts > 1) ? $clog2(num_harts) : 1;
    endfunction

endpackage

// File: rtl/vscale_tohost_fifo.sv
// Synchronous FIFO that accepts several pushes per cycle.
// Lanes are written in ascending index order; pushes that find no free slot
// are dropped and latch the sticky overflow flag. A pop is applied before the
// pushes of the same cycle, so push+pop on a full FIFO both succeed.
// DEPTH must be a power of two, at least 2.
module vscale_tohost_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [LANES-1:0]       push_i,
    input  logic [LANES*WIDTH-1:0] push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next-state: retire the head first, then place each pushing lane in order.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (pop_i && (cnt_q != '0)) begin
            rd_d  = rd_q + PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
        end
        for (int l = 0; l < LANES; l++) begin
            if (push_i[l]) begin
                if (cnt_d < FULL) begin
                    mem_d[wr_d] = push_data_i[l*WIDTH +: WIDTH];
                    wr_d        = wr_d + PW'(1);
                    cnt_d       = cnt_d + (PW+1)'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Storage and pointer registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign valid_o    = (cnt_q != '0);
    assign data_o     = mem_q[rd_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/vscale_tohost_monitor.sv
// End-of-test monitor: snoops each hart's dmem store port for writes to that
// hart's tohost word and latches a single pass/fail/timeout verdict.
// Optional console FIFO enabled by defining VSCALE_TOHOST_CONSOLE_EN.
//
// Handshake: a console byte transfers on a clock edge where cons_valid and
// cons_ready are both high; cons_data is stable while cons_valid is high and
// cons_ready is low.
module vscale_tohost_monitor
    import vscale_tohost_pkg::*;
#(
    parameter int                    NUM_HARTS     = 1,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_BASE   = ADDR_WIDTH'(32'h0000_1000),
    parameter logic [ADDR_WIDTH-1:0] HART_STRIDE   = ADDR_WIDTH'(32'h0000_0040),
    parameter int                    CYCLE_WIDTH   = 64,
    parameter int                    CONSOLE_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_HARTS-1:0]                 dmem_write,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0]      dmem_addr,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0]      dmem_wdata,
    input  logic [CYCLE_WIDTH-1:0]               max_cycles,
    output logic [CYCLE_WIDTH-1:0]               cycle_count,
    output logic [NUM_HARTS-1:0]                 hart_passed,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 fail,
    output logic                                 timeout,
    output logic [hart_idx_width(NUM_HARTS)-1:0] fail_hart,
    output logic [DATA_WIDTH-2:0]                fail_code,
    output logic                                 cons_valid,
    output logic [7:0]                           cons_data,
    input  logic                                 cons_ready,
    output logic                                 cons_overflow
);

    localparam int HW = hart_idx_width(NUM_HARTS);

    logic [NUM_HARTS-1:0]            hit_d, hit_q;
    logic [NUM_HARTS*DATA_WIDTH-1:0] data_q;

    tohost_state_e                   state_q, state_d;
    logic [CYCLE_WIDTH-1:0]          count_q, count_d;
    logic [NUM_HARTS-1:0]            passed_q, passed_d, passed_next, fail_req;
    logic [HW-1:0]                   fail_hart_q, fail_hart_d, req_idx;
    logic [DATA_WIDTH-2:0]           fail_code_q, fail_code_d, req_code;

    // Per-hart address match against that hart's own tohost word.
    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_match
        localparam logic [ADDR_WIDTH-1:0] HART_ADDR = TOHOST_BASE + HART_STRIDE * ADDR_WIDTH'(g);
        assign hit_d[g] = dmem_write[g] && (dmem_addr[g*ADDR_WIDTH +: ADDR_WIDTH] == HART_ADDR);
    end

    // Capture stage: register the match and the store data for every hart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            data_q <= '0;
        end else begin
            hit_q  <= hit_d;
            data_q <= dmem_wdata;
        end
    end

    // Decode captured stores into pass bits and fail requests; pick lowest failing hart.
    always_comb begin
        passed_next = passed_q;
        fail_req    = '0;
        req_idx     = '0;
        req_code    = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (hit_q[i] && !passed_q[i]) begin
                if (data_q[i*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(TOHOST_PASS)) begin
                    passed_next[i] = 1'b1;
                end else if (data_q[i*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                    fail_req[i] = 1'b1;
                end
            end
        end
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (fail_req[i]) begin
                req_idx  = HW'(i);
                req_code = data_q[i*DATA_WIDTH + 1 +: DATA_WIDTH - 1];
            end
        end
    end

    // Verdict FSM next-state: FAIL beats PASS beats TIMEOUT; counter runs only while staying in RUN.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        passed_d    = passed_q;
        fail_hart_d = fail_hart_q;
        fail_code_d = fail_code_q;
        if (state_q == RUN) begin
            passed_d = passed_next;
            if (|fail_req) begin
                state_d     = FAIL;
                fail_hart_d = req_idx;
                fail_code_d = req_code;
            end else if (&passed_next) begin
                state_d = PASS;
            end else if ((max_cycles != '0) && (count_q > max_cycles)) begin
                state_d = TIMEOUT;
            end
            if ((state_d == RUN) && (count_q != '1)) begin
                count_d = count_q + CYCLE_WIDTH'(1);
            end
        end
    end

    // Verdict FSM state and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            count_q     <= '0;
            passed_q    <= '0;
            fail_hart_q <= '0;
            fail_code_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            passed_q    <= passed_d;
            fail_hart_q <= fail_hart_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign cycle_count = count_q;
    assign hart_passed = passed_q;
    assign done        = (state_q != RUN);
    assign pass        = (state_q == PASS);
    assign fail        = (state_q == FAIL);
    assign timeout     = (state_q == TIMEOUT);
    assign fail_hart   = fail_hart_q;
    assign fail_code   = fail_code_q;

`ifdef VSCALE_TOHOST_CONSOLE_EN
    logic [NUM_HARTS-1:0]   cons_hit_d, cons_hit_q;
    logic [NUM_HARTS*8-1:0] cons_bytes;

    // Console match: store to tohost+4 with a non-zero low byte.
    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_cons
        localparam logic [ADDR_WIDTH-1:0] CONS_ADDR =
            TOHOST_BASE + HART_STRIDE * ADDR_WIDTH'(g) + ADDR_WIDTH'(CONSOLE_OFFSET);
        assign cons_hit_d[g] = dmem_write[g]
                             && (dmem_addr[g*ADDR_WIDTH +: ADDR_WIDTH] == CONS_ADDR)
                             && (dmem_wdata[g*DATA_WIDTH +: 8] != 8'h00);
        assign cons_bytes[g*8 +: 8] = data_q[g*DATA_WIDTH +: 8];
    end

    // Console capture stage, aligned with the shared data capture register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cons_hit_q <= '0;
        end else begin
            cons_hit_q <= cons_hit_d;
        end
    end

    vscale_tohost_fifo #(
        .WIDTH (8),
        .DEPTH (CONSOLE_DEPTH),
        .LANES (NUM_HARTS)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (cons_hit_q),
        .push_data_i (cons_bytes),
        .pop_i       (cons_valid && cons_ready),
        .valid_o     (cons_valid),
        .data_o      (cons_data),
        .overflow_o  (cons_overflow)
    );
`else
    logic [31:0] unused_cons;
    assign unused_cons   = {31'd0, cons_ready} ^ 32'(CONSOLE_DEPTH);
    assign cons_valid    = 1'b0;
    assign cons_data     = 8'h00;
    assign cons_overflow = 1'b0;
`endif

endmodule

// File: doc/vscale_tohost_monitor.md
Name: vscale_tohost_monitor

Overview:
- Synthesizable, parametrised end-of-test monitor for multi-hart vscale simulation and FPGA builds.
- Snoops each hart's data-memory write port for stores to that hart's tohost word.
- Decodes pass/fail codes and enforces a cycle timeout.
- Presents a latched, single-source test verdict to the bench top or an FPGA status register.

Parameters:
- NUM_HARTS, 1, number of snooped hart write ports.
- ADDR_WIDTH, 32, dmem address width.
- DATA_WIDTH, 32, tohost word width (HTIF PCR width).
- TOHOST_BASE, 32'h0000_1000, tohost address of hart 0.
- HART_STRIDE, 32'h0000_0040, address offset between consecutive harts' tohost words.
- CYCLE_WIDTH, 64, cycle counter and limit width.
- CONSOLE_DEPTH, 16, console FIFO depth; power of two; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dmem_write  in  NUM_HARTS  per-hart store strobe
- dmem_addr  in  NUM_HARTS*ADDR_WIDTH  per-hart store address; hart i occupies slice i
- dmem_wdata  in  NUM_HARTS*DATA_WIDTH  per-hart store data
- max_cycles  in  CYCLE_WIDTH  timeout limit; 0 disables the timeout
- cycle_count  out  CYCLE_WIDTH  cycles since reset release
- hart_passed  out  NUM_HARTS  sticky per-hart pass flags
- done  out  1  verdict reached
- pass  out  1  all harts passed
- fail  out  1  a hart reported failure
- timeout  out  1  limit exceeded with no verdict
- fail_hart  out  max(1,$clog2(NUM_HARTS))  index of the failing hart
- fail_code  out  DATA_WIDTH-1  tohost value >> 1
- cons_valid  out  1  console byte available
- cons_data  out  8  console byte
- cons_ready  in  1  console consumer accept
- cons_overflow  out  1  sticky: a console byte was dropped

Behaviour:
- Reset asserted (reset=0): every output and all internal state go to 0 asynchronously.
- Capture stage: one registered stage per hart.
  - hit_i <= dmem_write[i] && addr_i == TOHOST_BASE + i*HART_STRIDE.
  - data_i <= wdata_i.
  - Decode therefore sees a store one cycle after it appears on the bus.
- Decode of registered hit_i:
  - data 0: ignored.
  - data 1: sets hart_passed[i].
  - Other data: fail request carrying code data>>1.
  - Hits from a hart whose hart_passed bit is already set are ignored.
- Global FSM, RUN -> PASS | FAIL | TIMEOUT; the three terminal states hold until reset.
  - RUN->FAIL: any fail request. fail_hart = lowest requesting index; fail_code taken from that hart.
  - RUN->PASS: all hart_passed bits set, including bits set this cycle.
  - RUN->TIMEOUT: max_cycles != 0 and cycle_count > max_cycles.
  - Same-cycle priority: FAIL > PASS > TIMEOUT.
- Outputs are registered:
  - done = state != RUN.
  - pass, fail and timeout are one-hot with done.
- cycle_count:
  - Increments by 1 each clock in RUN, starting from 0 at the first edge after reset release.
  - Freezes on leaving RUN.
  - Saturates at all-ones.
- Reset asserted mid-run: immediate return to RUN with all counters, flags and FIFO cleared. Any pending capture-stage hit is discarded.

Optional Feature:
- Macro: VSCALE_TOHOST_CONSOLE_EN.
- Defined:
  - A store to tohost_i + 4 whose wdata[7:0] != 0 pushes wdata[7:0] into a shared CONSOLE_DEPTH FIFO after the capture stage.
  - Simultaneous pushes from several harts enter in ascending hart order. Pushes beyond free space are dropped and set cons_overflow.
  - Pop occurs on cons_valid && cons_ready. cons_data is valid from FIFO head.
  - Push and pop in the same cycle on a full FIFO succeed.
  - The FIFO keeps running after done.
- Undefined: cons_valid, cons_data and cons_overflow are tied 0; cons_ready is ignored; no FIFO logic is instantiated.

Decomposition:
- Package vscale_tohost_pkg holds:
  - The state enum: RUN, PASS, FAIL, TIMEOUT.
  - Localparams TOHOST_PASS=1 and CONSOLE_OFFSET=4.
  - A hart-index width function.
- Sub-module vscale_tohost_fifo: generic sync FIFO with multi-push per cycle; used only under the macro.

Test Plan:
- NUM_HARTS=1: hart 0 stores 1 to 0x1000 at cycle 10 -> done=pass=1 at cycle 12; cycle_count frozen at 11.
- NUM_HARTS=1: store 15 to 0x1000 -> fail=1, fail_code=7, fail_hart=0; a later store of 1 leaves fail set.
- NUM_HARTS=4:
  - harts 0, 1 and 3 pass -> done stays 0; hart 2 passes -> pass=1.
  - separately, harts 1 and 2 store codes 5 and 9 in the same cycle -> fail_hart=1, fail_code=2.
- max_cycles=100, no stores -> timeout=1 when cycle_count=101. max_cycles=0 -> no timeout after 10000 cycles.
- Stores to 0x1004 and 0x0FFC and a store of 0 to 0x1000 -> no state change. Reset asserted mid-run at cycle 50 -> all outputs 0 during reset, normal counting after release.
- With VSCALE_TOHOST_CONSOLE_EN and cons_ready=0, 17 console stores of 'A'..'Q' -> 16 bytes 'A'..'P' held, cons_overflow=1; raise cons_ready -> 'A'..'P' drained in order.
